mc_fetch_unit: RTL and testbench
================================

Name: mc_fetch_unit

Overview:
- Program-counter, instruction-register and memory-data-register stage of the multicycle MIPS datapath.
- Drives the opcode and instruction fields consumed by the main control FSM.
- Applies that FSM's PC/IR/memory strobes (pc_write, pc_write_condition_beq/bne, pcsrc, IorD, IR_write, memread, memwrite) to the unified instruction/data memory.
- Registers the ALU result and memory read data for the following multicycle state.

Parameters:
- XLEN, 32, datapath width (PC, addresses, data).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- pc_write  in  1  unconditional PC update strobe
- pc_write_condition_beq  in  1  PC update if zero==1
- pc_write_condition_bne  in  1  PC update if zero==0
- zero  in  1  ALU zero flag (current cycle)
- pcsrc  in  2  next-PC select
- IorD  in  1  memory address select: 0=PC, 1=alu_out
- IR_write  in  1  load IR from mem_rdata
- memread  in  1  memory read strobe (pass-through)
- memwrite  in  1  memory write strobe (pass-through)
- alu_result  in  XLEN  combinational ALU output
- rs_data  in  XLEN  register-file rs read value (jr target)
- rt_data  in  XLEN  register-file rt read value (store data)
- mem_rdata  in  XLEN  memory read data
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data (=rt_data)
- mem_re  out  1  =memread
- mem_we  out  1  =memwrite, forced 0 when address misaligned
- pc  out  XLEN  current PC register
- ir  out  XLEN  instruction register
- opcode  out  6  ir[31:26], to control FSM
- mdr  out  XLEN  memory data register
- alu_out  out  XLEN  registered ALU result
- misalign  out  1  sticky misaligned-access flag
- instr_count  out  32  count of IR loads (fetched instructions)

Behaviour:
- Reset (async, any time incl. mid-instruction): pc=RESET_PC; ir=0 (opcode 0); mdr=0; alu_out=0; misalign=0; instr_count=0. Outputs derived from these take values on reset assertion, not at the next edge.
- pc_en = pc_write | (pc_write_condition_beq & zero) | (pc_write_condition_bne & ~zero). When pc_en, pc <= next_pc at clk edge; else pc holds.
- next_pc by pcsrc:
  - 00 = alu_result (PC+4 during fetch)
  - 01 = alu_out (branch target computed in decode)
  - 10 = {pc[31:28], ir[25:0], 2'b00} (jump)
  - 11 = rs_data (jr)
- pc_write together with a condition strobe: unconditional update wins.
- mem_addr = IorD ? alu_out : pc, combinational.
- IR_write: ir <= mem_rdata; instr_count <= instr_count+1, wrapping 2^32-1 -> 0. IR holds otherwise.
- mdr <= mem_rdata every cycle. alu_out <= alu_result every cycle. Both are single-cycle latency.
- Misalign: when (memread|memwrite) and mem_addr[1:0]!=0 at a clock edge, misalign <= 1. It stays sticky until reset; mem_we is suppressed in that cycle; reads still pass through. IR_write on a misaligned fetch still loads ir (flag only).
- memread and memwrite both high: both pass through, no arbitration (FSM never does this; bench flags it via assertion).
- All outputs glitch-free registered values except mem_addr, mem_wdata, mem_re, mem_we, opcode (combinational from registers/inputs).

Decomposition:
- Shared package mc_pkg: typedef pcsrc_t (PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10, PCSRC_JR=2'b11); localparams OPCODE_MSB=31, OPCODE_LSB=26, JTARGET_W=26; RESET_PC default. Controller and this block both import it.
- One sub-module: mc_next_pc (combinational pcsrc mux + pc_en logic), instantiated once; registers stay in top.

Test Plan:
- Reset mid-run: pc=0x40, ir nonzero; assert reset asynchronously between edges -> pc=0, ir=0, opcode=0, instr_count=0 immediately.
- Fetch: pc=0, IorD=0, memread=1, IR_write=1, pc_write=1, pcsrc=00, alu_result=4, mem_rdata=0x8C220008 -> next edge: ir=0x8C220008, opcode=6'h23, pc=4, instr_count=1; mem_addr=0 during the cycle.
- Branches: pcsrc=01, alu_out=0x100, beq=1 with zero=1 -> pc=0x100. Same with zero=0 -> pc unchanged. bne=1, zero=0 -> pc=0x100.
- Jump/jr: pc=0x1000_0010, ir=0x0800_0040, pcsrc=10, pc_write=1 -> pc=0x1000_0100. pcsrc=11, rs_data=0x2000 -> pc=0x2000.
- Store via IorD: IorD=1, alu_out=0x203, memwrite=1 -> mem_addr=0x203, mem_we=0, misalign=1 and stays 1 after a later aligned access. Aligned 0x200 after reset -> mem_we=1, mem_wdata=rt_data.
- Counter wrap: force instr_count=0xFFFF_FFFF, pulse IR_write -> instr_count=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS datapath.
// Imported by the control FSM and the fetch unit.
package mc_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pcsrc_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JTARGET_W  = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mc_fetch_unit_if.sv
// Unified instruction/data memory bus between the fetch unit and memory.
// The fetch unit is the master; the memory model is the slave.
interface mc_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_re;
  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_re,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_re,
    input  mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mc_next_pc.sv
// Next-PC select and PC write-enable for the multicycle datapath.
// Purely combinational; the PC register lives in the top.
module mc_next_pc
  import mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  pcsrc_t                 pcsrc,
  input  logic                   pc_write,
  input  logic                   pc_write_condition_beq,
  input  logic                   pc_write_condition_bne,
  input  logic                   zero,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        alu_out,
  input  logic [XLEN-1:0]        pc,
  input  logic [JTARGET_W-1:0]   jtarget,
  input  logic [XLEN-1:0]        rs_data,
  output logic [XLEN-1:0]        next_pc,
  output logic                   pc_en
);

  // Unconditional write dominates simply by being OR-ed in.
  assign pc_en = pc_write
               | (pc_write_condition_beq & zero)
               | (pc_write_condition_bne & ~zero);

  always_comb begin
    next_pc = alu_result;
    unique case (pcsrc)
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = {pc[XLEN-1:XLEN-4], jtarget, 2'b00};
      PCSRC_JR:     next_pc = rs_data;
      default:      next_pc = alu_result;
    endcase
  end

endmodule

// File: rtl/mc_fetch_unit.sv
// PC, IR, MDR and ALU-out registers of the multicycle MIPS datapath,
// plus the unified memory address/strobe generation.
module mc_fetch_unit
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write,
  input  logic                 pc_write_condition_beq,
  input  logic                 pc_write_condition_bne,
  input  logic                 zero,
  input  pcsrc_t               pcsrc,
  input  logic                 IorD,
  input  logic                 IR_write,
  input  logic                 memread,
  input  logic                 memwrite,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      rs_data,
  input  logic [XLEN-1:0]      rt_data,
  mc_fetch_unit_if.master      mem,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      ir,
  output logic [5:0]           opcode,
  output logic [XLEN-1:0]      mdr,
  output logic [XLEN-1:0]      alu_out,
  output logic                 misalign,
  output logic [31:0]          instr_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] mdr_q;
  logic [XLEN-1:0] alu_out_q;
  logic            misalign_q, misalign_d;
  logic [31:0]     instr_count_q, instr_count_d;

  logic [XLEN-1:0] next_pc;
  logic            pc_en;
  logic            addr_bad;
  logic            mem_access;

  mc_next_pc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pcsrc                  (pcsrc),
    .pc_write               (pc_write),
    .pc_write_condition_beq (pc_write_condition_beq),
    .pc_write_condition_bne (pc_write_condition_bne),
    .zero                   (zero),
    .alu_result             (alu_result),
    .alu_out                (alu_out_q),
    .pc                     (pc_q),
    .jtarget                (ir_q[JTARGET_W-1:0]),
    .rs_data                (rs_data),
    .next_pc                (next_pc),
    .pc_en                  (pc_en)
  );

  assign mem.mem_addr  = IorD ? alu_out_q : pc_q;
  assign mem.mem_wdata = rt_data;
  assign mem.mem_re    = memread;

  assign addr_bad   = |mem.mem_addr[1:0];
  assign mem_access = memread | memwrite;

  // Misaligned stores are dropped; reads and IR loads still go through.
  assign mem.mem_we = memwrite & ~addr_bad;

  assign pc_d          = pc_en ? next_pc : pc_q;
  assign ir_d          = IR_write ? mem.mem_rdata : ir_q;
  assign instr_count_d = IR_write ? instr_count_q + 32'd1 : instr_count_q;
  assign misalign_d    = misalign_q | (mem_access & addr_bad);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      mdr_q         <= '0;
      alu_out_q     <= '0;
      misalign_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      mdr_q         <= mem.mem_rdata;
      alu_out_q     <= alu_result;
      misalign_q    <= misalign_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign mdr         = mdr_q;
  assign alu_out     = alu_out_q;
  assign misalign    = misalign_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Directed bench for mc_fetch_unit: reset, fetch, branches,
// jumps, misaligned store and instruction-counter wrap.
module tb_mc_fetch_unit;
  import mc_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            pc_write;
  logic            pc_write_condition_beq;
  logic            pc_write_condition_bne;
  logic            zero;
  pcsrc_t          pcsrc;
  logic            IorD;
  logic            IR_write;
  logic            memread;
  logic            memwrite;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ir;
  logic [5:0]      opcode;
  logic [XLEN-1:0] mdr;
  logic [XLEN-1:0] alu_out;
  logic            misalign;
  logic [31:0]     instr_count;

  int n_total;
  int n_pass;

  mc_fetch_unit_if #(.XLEN(XLEN)) mem ();

  mc_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .pc_write               (pc_write),
    .pc_write_condition_beq (pc_write_condition_beq),
    .pc_write_condition_bne (pc_write_condition_bne),
    .zero                   (zero),
    .pcsrc                  (pcsrc),
    .IorD                   (IorD),
    .IR_write               (IR_write),
    .memread                (memread),
    .memwrite               (memwrite),
    .alu_result             (alu_result),
    .rs_data                (rs_data),
    .rt_data                (rt_data),
    .mem                    (mem.master),
    .pc                     (pc),
    .ir                     (ir),
    .opcode                 (opcode),
    .mdr                    (mdr),
    .alu_out                (alu_out),
    .misalign               (misalign),
    .instr_count            (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The control FSM must never read and write in the same cycle.
  always @(negedge clk) begin
    if (!reset)
      assert (!(memread && memwrite))
        else $error("FAIL rw_both: memread and memwrite both high");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_write               = 1'b0;
    pc_write_condition_beq = 1'b0;
    pc_write_condition_bne = 1'b0;
    IR_write               = 1'b0;
    memread                = 1'b0;
    memwrite               = 1'b0;
    IorD                   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    idle();
    zero          = 1'b0;
    pcsrc         = PCSRC_ALU;
    alu_result    = '0;
    rs_data       = '0;
    rt_data       = '0;
    mem.mem_rdata = '0;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_icount", instr_count, 32'h0);
    #4;
    reset = 1'b0;

    // Fetch
    memread       = 1'b1;
    IR_write      = 1'b1;
    pc_write      = 1'b1;
    pcsrc         = PCSRC_ALU;
    alu_result    = 32'h4;
    mem.mem_rdata = 32'h8C22_0008;
    #1;
    chk("fetch_addr", mem.mem_addr, 32'h0);
    chk("fetch_re", {31'b0, mem.mem_re}, 32'h1);
    step();
    chk("fetch_ir", ir, 32'h8C22_0008);
    chk("fetch_opc", {26'b0, opcode}, 32'h23);
    chk("fetch_pc", pc, 32'h4);
    chk("fetch_icount", instr_count, 32'h1);
    chk("fetch_mdr", mdr, 32'h8C22_0008);
    chk("fetch_aluout", alu_out, 32'h4);

    // Branch target into alu_out
    idle();
    alu_result = 32'h100;
    step();
    chk("br_aluout", alu_out, 32'h100);
    chk("br_pc_hold", pc, 32'h4);
    pcsrc                  = PCSRC_ALUOUT;
    pc_write_condition_beq = 1'b1;
    zero                   = 1'b0;
    step();
    chk("beq_nt", pc, 32'h4);
    zero = 1'b1;
    step();
    chk("beq_t", pc, 32'h100);

    idle();
    pc_write   = 1'b1;
    pcsrc      = PCSRC_ALU;
    alu_result = 32'h8;
    step();
    chk("pc_8", pc, 32'h8);
    idle();
    alu_result = 32'h100;
    step();
    pcsrc                  = PCSRC_ALUOUT;
    pc_write_condition_bne = 1'b1;
    zero                   = 1'b1;
    step();
    chk("bne_nt", pc, 32'h8);
    pc_write = 1'b1;
    step();
    chk("pcw_wins", pc, 32'h100);
    idle();
    pc_write   = 1'b1;
    pcsrc      = PCSRC_ALU;
    alu_result = 32'h8;
    step();
    idle();
    alu_result = 32'h100;
    step();
    pcsrc                  = PCSRC_ALUOUT;
    pc_write_condition_bne = 1'b1;
    zero                   = 1'b0;
    step();
    chk("bne_t", pc, 32'h100);

    // Jump and jr
    idle();
    pc_write      = 1'b1;
    IR_write      = 1'b1;
    memread       = 1'b1;
    pcsrc         = PCSRC_ALU;
    alu_result    = 32'h1000_0010;
    mem.mem_rdata = 32'h0800_0040;
    step();
    chk("j_pc0", pc, 32'h1000_0010);
    chk("j_ir", ir, 32'h0800_0040);
    chk("j_opc", {26'b0, opcode}, 32'h02);
    idle();
    pc_write = 1'b1;
    pcsrc    = PCSRC_JUMP;
    step();
    chk("jump", pc, 32'h1000_0100);
    pcsrc   = PCSRC_JR;
    rs_data = 32'h2000;
    step();
    chk("jr", pc, 32'h2000);

    // Misaligned store
    idle();
    alu_result = 32'h203;
    step();
    IorD     = 1'b1;
    memwrite = 1'b1;
    rt_data  = 32'hDEAD_BEEF;
    #1;
    chk("mis_addr", mem.mem_addr, 32'h203);
    chk("mis_we", {31'b0, mem.mem_we}, 32'h0);
    chk("mis_wdata", mem.mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    memwrite   = 1'b0;
    alu_result = 32'h200;
    step();
    memwrite = 1'b1;
    #1;
    chk("mis_al_we", {31'b0, mem.mem_we}, 32'h1);
    step();
    chk("mis_sticky", {31'b0, misalign}, 32'h1);

    // Async reset between edges
    idle();
    pc_write      = 1'b1;
    IR_write      = 1'b1;
    memread       = 1'b1;
    pcsrc         = PCSRC_ALU;
    alu_result    = 32'h40;
    mem.mem_rdata = 32'h1234_5678;
    step();
    chk("pre_rst_pc", pc, 32'h40);
    chk("pre_rst_ir", ir, 32'h1234_5678);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_opc", {26'b0, opcode}, 32'h0);
    chk("arst_icount", instr_count, 32'h0);
    chk("arst_misalign", {31'b0, misalign}, 32'h0);
    chk("arst_mdr", mdr, 32'h0);
    chk("arst_aluout", alu_out, 32'h0);
    reset = 1'b0;

    // Aligned store after reset
    alu_result = 32'h200;
    step();
    IorD     = 1'b1;
    memwrite = 1'b1;
    rt_data  = 32'hCAFE_F00D;
    #1;
    chk("st_addr", mem.mem_addr, 32'h200);
    chk("st_we", {31'b0, mem.mem_we}, 32'h1);
    chk("st_wdata", mem.mem_wdata, 32'hCAFE_F00D);
    step();
    chk("st_noflag", {31'b0, misalign}, 32'h0);

    // Counter wrap
    idle();
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    chk("wrap_pre", instr_count, 32'hFFFF_FFFF);
    IR_write      = 1'b1;
    mem.mem_rdata = 32'h0000_0020;
    step();
    chk("wrap", instr_count, 32'h0);
    chk("wrap_ir", ir, 32'h0000_0020);
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
